// File: rtl/ula_arbiter_if.sv
// ============================================================================
// Module      : ula_arbiter_if
// Description : Bundles the two requester handshakes and the ULA-facing bus of
//               the ULA arbiter. The slave modport is the arbiter's view; the
//               master modport is the view of the requesters plus the ULA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ula_arbiter_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
);
   // Requester 0 (execute stage)
   logic              r0_valid;
   logic              r0_ready;
   logic [CTRL_W-1:0] r0_op;
   logic [WIDTH-1:0]  r0_a;
   logic [WIDTH-1:0]  r0_b;
   logic              r0_rsp_valid;
   logic              r0_rsp_ready;
   logic [WIDTH-1:0]  r0_result;
   logic              r0_zero;
   // Requester 1 (address/branch unit)
   logic              r1_valid;
   logic              r1_ready;
   logic [CTRL_W-1:0] r1_op;
   logic [WIDTH-1:0]  r1_a;
   logic [WIDTH-1:0]  r1_b;
   logic              r1_rsp_valid;
   logic              r1_rsp_ready;
   logic [WIDTH-1:0]  r1_result;
   logic              r1_zero;
   // Shared combinational ULA
   logic [CTRL_W-1:0] ula_ctrl;
   logic [WIDTH-1:0]  ula_a;
   logic [WIDTH-1:0]  ula_b;
   logic [WIDTH-1:0]  ula_result;
   logic              ula_zero;
   // Status
   logic              busy;

   modport slave (
      input  r0_valid, r0_op, r0_a, r0_b, r0_rsp_ready,
      output r0_ready, r0_rsp_valid, r0_result, r0_zero,
      input  r1_valid, r1_op, r1_a, r1_b, r1_rsp_ready,
      output r1_ready, r1_rsp_valid, r1_result, r1_zero,
      output ula_ctrl, ula_a, ula_b,
      input  ula_result, ula_zero,
      output busy
   );

   modport master (
      output r0_valid, r0_op, r0_a, r0_b, r0_rsp_ready,
      input  r0_ready, r0_rsp_valid, r0_result, r0_zero,
      output r1_valid, r1_op, r1_a, r1_b, r1_rsp_ready,
      input  r1_ready, r1_rsp_valid, r1_result, r1_zero,
      input  ula_ctrl, ula_a, ula_b,
      output ula_result, ula_zero,
      input  busy
   );
endinterface

`default_nettype wire

// File: rtl/ula_arbiter.sv
// ============================================================================
// Module      : ula_arbiter
// Description : Round-robin arbiter sharing one combinational ULA between two
//               requesters. One operation in flight: IDLE -> EXEC -> RESP.
//               Operands are latched on accept and held on the ULA bus; the
//               ULA output is registered per requester at the end of EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   ula_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner;       // requester of the operation in flight
   logic              r_last_grant;  // requester served most recently
   logic [CTRL_W-1:0] r_op;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_res0;
   logic [WIDTH-1:0]  r_res1;
   logic              r_zero0;
   logic              r_zero1;

   logic              w_grant0;
   logic              w_grant1;
   logic              w_acc0;
   logic              w_acc1;
   logic              w_rsp_ack;

   // Arbitration, handshakes and next-state decode
   always_comb begin
      w_state_nxt      = r_state;
      w_grant0         = 1'b0;
      w_grant1         = 1'b0;
      w_rsp_ack        = 1'b0;
      bus.r0_ready     = 1'b0;
      bus.r1_ready     = 1'b0;
      bus.r0_rsp_valid = 1'b0;
      bus.r1_rsp_valid = 1'b0;

      // With both valid the requester not served last time wins
      w_grant0 = bus.r0_valid & (~bus.r1_valid |  r_last_grant);
      w_grant1 = bus.r1_valid & (~bus.r0_valid | ~r_last_grant);

      unique case (r_state)
         S_IDLE: begin
            // Gated by rst_n so nothing is offered while reset is asserted
            bus.r0_ready = rst_n & w_grant0;
            bus.r1_ready = rst_n & w_grant1;
            if (w_grant0 | w_grant1) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            bus.r0_rsp_valid = ~r_owner;
            bus.r1_rsp_valid =  r_owner;
            w_rsp_ack        = r_owner ? bus.r1_rsp_ready : bus.r0_rsp_ready;
            if (w_rsp_ack) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_acc0 = bus.r0_valid & bus.r0_ready;
   assign w_acc1 = bus.r1_valid & bus.r1_ready;

   // State register, operand latch, result capture and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_res0       <= '0;
         r_res1       <= '0;
         r_zero0      <= 1'b0;
         r_zero1      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && (w_acc0 || w_acc1)) begin
            r_owner <= w_acc1;
            r_op    <= w_acc1 ? bus.r1_op : bus.r0_op;
            r_a     <= w_acc1 ? bus.r1_a  : bus.r0_a;
            r_b     <= w_acc1 ? bus.r1_b  : bus.r0_b;
         end
         if (r_state == S_EXEC) begin
            if (r_owner) begin
               r_res1  <= bus.ula_result;
               r_zero1 <= bus.ula_zero;
            end else begin
               r_res0  <= bus.ula_result;
               r_zero0 <= bus.ula_zero;
            end
         end
         if (r_state == S_RESP && w_rsp_ack) begin
            r_last_grant <= r_owner;
         end
      end
   end

   assign bus.ula_ctrl  = r_op;
   assign bus.ula_a     = r_a;
   assign bus.ula_b     = r_b;
   assign bus.r0_result = r_res0;
   assign bus.r0_zero   = r_zero0;
   assign bus.r1_result = r_res1;
   assign bus.r1_zero   = r_zero1;
   assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
